// File: rtl/ram_sync_2p_clr.sv
// ram_sync_2p_clr: 1W/1R synchronous DFF RAM with registered read, collision mode and clear sweep
module ram_sync_2p_clr #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0,
  parameter bit BYPASS = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic idle, last, hit;
  assign idle = state == IDLE;
  assign last = &ptr;
  assign hit  = wr_en & rd_en & (wr_addr == rd_addr);
  assign busy = state == CLEAR;
  // ptr wraps to 0 on the last word, which is exactly where the sweep hands over to IDLE
  always_comb begin
    state_nx = idle ? (clr ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
    ptr_nx   = idle ? '0 : ptr + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR;
      ptr      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      rd_valid <= idle & rd_en;
      if (idle & rd_en) rd_data <= (BYPASS && hit) ? wr_data : mem[rd_addr];
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && busy) mem[ptr] <= INIT_VAL;
    else if (!reset && idle && wr_en) mem[wr_addr] <= wr_data;
  end
endmodule
